mdu: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS core. It sits beside the ALU in the execute stage and consumes the same rs/rt operands the datapath reads from the register file. It implements mult/multu/div/divu with a fixed busy latency, mthi/mtlo writes, and holds the HI/LO registers that mfhi/mflo read back. The controller stalls issue while `busy` is high.

---
 rtl/mdu.sv | 209 ++++++++++++++++++++
 tb/tb_mdu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// ----------------------------------------------------------------------------
// mdu - multi-cycle multiply/divide unit with HI/LO registers.
//
// Executes multu/mult/divu/div with a fixed busy latency and mthi/mtlo writes.
// HI/LO always show the last committed results; a multiply/divide result is
// held in pending registers until the counter expires, then committed.
//
// Optional feature macro: MDU_DIV_EN
//   defined   : divu/div (op 010/011) are implemented.
//   undefined : divider compiled out; op 010/011 behave as no-ops and
//               DIV_CYCLES has no effect.
//
// Parameters:
//   MULT_CYCLES  busy cycles for multu/mult (1..15)
//   DIV_CYCLES   busy cycles for divu/div   (1..15)
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset
//   start  in   1   request strobe, sampled with op/a/b
//   op     in   3   000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   operation in flight (registered)
//   done   out  1   one-cycle pulse after HI/LO commit (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
// ----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul_s;
  logic        is_div_s;
  logic        last_s;
  logic        accept_s;
  logic [3:0]  cnt_load_s;
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Request decode; a new request is also taken on the final busy edge
  // so that back-to-back issue loses no cycle.
  always_comb begin
    is_mul_s   = (op[2:1] == 2'b00);
`ifdef MDU_DIV_EN
    is_div_s   = (op[2:1] == 2'b01);
`else
    is_div_s   = 1'b0;
`endif
    last_s     = (state_q == ST_BUSY) && (cnt_q == 4'd1);
    accept_s   = start && ((state_q == ST_IDLE) || last_s);
    cnt_load_s = op[1] ? DIV_CNT : MULT_CNT;
  end

  // 64-bit product: sign-extending both operands to 64 bits makes the
  // low 64 bits of an unsigned multiply equal the signed product.
  always_comb begin
    mul_a_s = {{32{op[0] & a[31]}}, a};
    mul_b_s = {{32{op[0] & b[31]}}, b};
    prod_s  = mul_a_s * mul_b_s;
  end

`ifdef MDU_DIV_EN
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  // Sign-magnitude divide: the magnitude quotient truncates toward zero,
  // and 0x80000000 / -1 wraps back to 0x80000000 naturally.
  always_comb begin
    neg_a_s = op[0] & a[31];
    neg_b_s = op[0] & b[31];
    abs_a_s = neg_a_s ? (32'd0 - a) : a;
    abs_b_s = neg_b_s ? (32'd0 - b) : b;
    if (abs_b_s == 32'd0) begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end else begin
      uq_s = abs_a_s / abs_b_s;
      ur_s = abs_a_s % abs_b_s;
    end
    quo_s = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
    rem_s = neg_a_s ? (32'd0 - ur_s) : ur_s;
  end
`else
  assign quo_s = 32'd0;
  assign rem_s = 32'd0;
`endif

  // Next-state: countdown/commit first, then a newly accepted request,
  // so an mthi/mtlo on the commit edge overrides the committed value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        state_d = ST_BUSY;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
      if (is_mul_s) begin
        state_d   = ST_BUSY;
        cnt_d     = cnt_load_s;
        pend_hi_d = prod_s[63:32];
        pend_lo_d = prod_s[31:0];
        pend_wr_d = 1'b1;
      end else if (is_div_s) begin
        state_d   = ST_BUSY;
        cnt_d     = cnt_load_s;
        pend_hi_d = rem_s;
        pend_lo_d = quo_s;
        pend_wr_d = (b != 32'd0);
      end else if (op == 3'b100) begin
        hi_d = a;
      end else if (op == 3'b101) begin
        lo_d = a;
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ----------------------------------------------------------------------------
// tb_mdu - directed self-checking bench for mdu (default MULT 5 / DIV 10).
// Divide vectors depend on whether MDU_DIV_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for exactly one accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
  endtask

  // count sampled busy cycles until busy drops (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) check_eq("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'b110;
    a     = 32'd0;
    b     = 32'd0;
    tick();
    tick();
    reset = 1'b1;
    check_eq("rst_hi",   hi, 32'd0);
    check_eq("rst_lo",   lo, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    tick();

    // multu 0xFFFFFFFF * 2
    issue(3'b000, 32'hFFFF_FFFF, 32'd2);
    check_eq("multu_busy0", 32'(busy), 32'd1);
    check_eq("multu_done0", 32'(done), 32'd0);
    check_eq("multu_hold_lo", lo, 32'd0);
    wait_idle(n);
    check_eq("multu_cycles", 32'(n), 32'd5);
    check_eq("multu_done", 32'(done), 32'd1);
    check_eq("multu_hi", hi, 32'h0000_0001);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);
    tick();
    check_eq("multu_done_pulse", 32'(done), 32'd0);

    // mult -1 * 2
    issue(3'b001, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check_eq("mult_cycles", 32'(n), 32'd5);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFFE);
    tick();

    // mthi while idle
    issue(3'b100, 32'h1234_5678, 32'd0);
    check_eq("mthi_hi", hi, 32'h1234_5678);
    check_eq("mthi_lo", lo, 32'hFFFF_FFFE);
    check_eq("mthi_busy", 32'(busy), 32'd0);
    tick();
    check_eq("mthi_done", 32'(done), 32'd0);

    // mtlo while multu busy is ignored; operand changes ignored too
    issue(3'b000, 32'd3, 32'd4);
    issue(3'b101, 32'hDEAD_BEEF, 32'd99);
    check_eq("mtlo_ignored", lo, 32'hFFFF_FFFE);
    wait_idle(n);
    check_eq("mtlo_cycles", 32'(n + 1), 32'd5);
    check_eq("mtlo_lo", lo, 32'd12);
    check_eq("mtlo_hi", hi, 32'd0);
    tick();

`ifdef MDU_DIV_EN
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check_eq("div_cycles", 32'(n), 32'd10);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    tick();
    issue(3'b010, 32'd7, 32'd0);
    wait_idle(n);
    check_eq("div0_cycles", 32'(n), 32'd10);
    check_eq("div0_done", 32'(done), 32'd1);
    check_eq("div0_lo", lo, 32'hFFFF_FFFD);
    check_eq("div0_hi", hi, 32'hFFFF_FFFF);
    tick();
    issue(3'b010, 32'd10, 32'd3);
    wait_idle(n);
    check_eq("divu_lo", lo, 32'd3);
    check_eq("divu_hi", hi, 32'd1);
    tick();
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_eq("divovf_lo", lo, 32'h8000_0000);
    check_eq("divovf_hi", hi, 32'd0);
    tick();
`else
    issue(3'b010, 32'd10, 32'd3);
    check_eq("nodiv_busy", 32'(busy), 32'd0);
    tick();
    check_eq("nodiv_done", 32'(done), 32'd0);
    check_eq("nodiv_lo", lo, 32'd12);
    check_eq("nodiv_hi", hi, 32'd0);
`endif

    // back-to-back: start held, second request taken on the falling-busy edge
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd5;
    b     = 32'd6;
    tick();
    a = 32'd7;
    b = 32'd8;
    for (int i = 0; i < 4; i++) tick();
    check_eq("b2b_busy_mid", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    check_eq("b2b_done", 32'(done), 32'd1);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_lo1", lo, 32'd30);
    wait_idle(n);
    check_eq("b2b_cycles", 32'(n), 32'd5);
    check_eq("b2b_lo2", lo, 32'd56);
    tick();

    // reset mid-operation: immediate clear, no later done
    issue(3'b000, 32'd3, 32'd4);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_hi",   hi, 32'd0);
    check_eq("arst_lo",   lo, 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("arst_nodone", 32'(done), 32'd0);
    end
    check_eq("arst_lo_after", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
